// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with a small TX FIFO, one-byte RX holding register and IRQ.
// Optional build macro UART_LOOPBACK_EN: receiver fed from the internal transmitter, TX pin held high.
module uart_mmio #(
    parameter int BAUD_DIV = 5208,
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irqout
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [PW:0]   FIFO_CAP  = (PW + 1)'(TX_DEPTH);

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;
    localparam logic [31:0] ADDR_IEN = 32'h4000_0024;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic sel_txd, sel_rxd, sel_con, sel_ien;
    logic txd_write, rxd_read, con_write, ien_write;

    assign sel_txd   = (addr == ADDR_TXD);
    assign sel_rxd   = (addr == ADDR_RXD);
    assign sel_con   = (addr == ADDR_CON);
    assign sel_ien   = (addr == ADDR_IEN);
    assign txd_write = wr & sel_txd;
    assign rxd_read  = rd & sel_rxd;
    assign con_write = wr & sel_con;
    assign ien_write = wr & sel_ien;

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] fifo_count;
    logic        fifo_empty, fifo_full, push, pop;

    tx_state_t   tx_state;
    logic [CW-1:0] tx_baud;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_reg;
    logic        tx_baud_done, tx_idle, tx_overflow;

    assign fifo_empty   = (fifo_count == '0);
    assign fifo_full    = (fifo_count == FIFO_CAP);
    assign tx_baud_done = (tx_baud == BAUD_LAST);
    // Full is judged before the edge, so a simultaneous pop never rescues a push.
    assign push    = txd_write & ~fifo_full;
    assign pop     = ~fifo_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_baud_done));
    assign tx_idle = fifo_empty & (tx_state == TX_IDLE);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tx_overflow <= 1'b0;
        else if (txd_write && fifo_full)
            tx_overflow <= 1'b1;
        else if (con_write && wdata[5])
            tx_overflow <= 1'b0;
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_reg   <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_state <= TX_START;
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_baud  <= '0;
                        tx_reg   <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_baud_done) begin
                        tx_state <= TX_DATA;
                        tx_baud  <= '0;
                        tx_bit   <= '0;
                        tx_reg   <= tx_shift[0];
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_baud_done) begin
                        tx_baud <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            tx_reg   <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_reg   <= tx_shift[1];
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                default: begin
                    if (tx_baud_done) begin
                        tx_baud <= '0;
                        if (!fifo_empty) begin
                            tx_state <= TX_START;
                            tx_shift <= fifo_mem[rd_ptr];
                            tx_reg   <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic rx_src, sync1, sync2, sync3;
    logic unused_bits;

`ifdef UART_LOOPBACK_EN
    assign rx_src      = tx_reg;
    assign UART_TX     = 1'b1;
    assign unused_bits = ^{wdata[31:8], UART_RX};
`else
    assign rx_src      = UART_RX;
    assign UART_TX     = tx_reg;
    assign unused_bits = ^wdata[31:8];
`endif

    // sync3 is the previous synchronized sample, used only for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rx_src;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    rx_state_t   rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift, rx_byte;
    logic        rx_valid, rx_overrun, frame_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rxd_read)                rx_valid   <= 1'b0;
            if (con_write && wdata[3])   rx_overrun <= 1'b0;
            if (con_write && wdata[4])   frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (sync3 && !sync2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BAUD_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {sync2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == BAUD_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (sync2) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                            // A read landing on the completion edge consumes the old byte.
                            if (rx_valid && !rxd_read) rx_overrun <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- IEN / IRQ ----------------
    logic [1:0] ien;
    logic       irq_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ien     <= 2'b00;
            irq_reg <= 1'b0;
        end else begin
            if (ien_write) ien <= wdata[1:0];
            irq_reg <= (ien[0] & rx_valid) | (ien[1] & tx_idle);
        end
    end

    assign irqout = irq_reg;

    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            if (sel_rxd)
                rdata = {24'd0, rx_byte};
            else if (sel_con)
                rdata = {26'd0, tx_overflow, frame_err, rx_overrun, fifo_full, tx_idle, rx_valid};
            else if (sel_ien)
                rdata = {30'd0, ien};
        end
    end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped 8N1 UART transceiver hanging off the pipelined CPU's MEM-stage data bus, alongside data memory and the LED/switch/digit peripheral. The CPU's EX_MEM stage drives `rd`/`wr`/`addr`/`wdata`; the CPU's read-data mux selects `rdata` for addresses at and above 0x40000018. Transmit path is buffered by a small FIFO so store bursts do not stall software. Receive path holds one byte and raises an interrupt request.

## Interface
- `BAUD_DIV`, 5208: clocks per bit (50 MHz / 9600); ≥ 4, even.
- `TX_DEPTH`, 4: TX FIFO entries; power of two, ≥ 2.
- `clk` input 1: CPU clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rd` input 1: bus read strobe (EX_MEM MemRd).
- `wr` input 1: bus write strobe (EX_MEM MemWr).
- `addr` input 32: bus byte address (EX_MEM ALUOut).
- `wdata` input 32: bus write data.
- `rdata` output 32: bus read data, combinational.
- `UART_RX` input 1: serial in, asynchronous to `clk`.
- `UART_TX` output 1: serial out, registered.
- `irqout` output 1: level interrupt request, registered.

## Operation
- Register map, full 32-bit decode, other addresses ignored:
  - 0x40000018 TXD: write pushes `wdata[7:0]` into TX FIFO; read returns 0.
  - 0x4000001C RXD: read returns {24'b0, rx_byte}; read with rx_valid=1 clears rx_valid at that edge.
  - 0x40000020 CON (read): [0] rx_valid, [1] tx_idle (FIFO empty and TX FSM IDLE), [2] tx_full, [3] rx_overrun, [4] frame_err, [5] tx_overflow; others 0. Write: 1 in bit 3/4/5 clears that sticky flag.
  - 0x40000024 IEN: R/W bits [1:0]; bit0 enables RX interrupt, bit1 enables TX-idle interrupt.
- `rdata` = 0 when `rd`=0 or address unmapped.
- TX FIFO: write to full FIFO is dropped and sets tx_overflow; push and pop in the same cycle on a full FIFO: pop happens, push is dropped (count judged before the edge). Pointers wrap modulo TX_DEPTH.
- TX FSM: IDLE → START (pop FIFO head, drive 0) → DATA (8 bits, LSB first) → STOP (drive 1) → START if FIFO non-empty, else IDLE. Each of START/bit/STOP lasts exactly BAUD_DIV clocks.
- RX: two-flop synchronizer. IDLE → START on a synchronized 1→0; at BAUD_DIV/2 the line is re-checked: 1 → IDLE (glitch), 0 → DATA. Each data bit and the stop bit sampled BAUD_DIV clocks later (mid-bit). Stop=1: byte latched, rx_valid set; if rx_valid already 1, byte overwrites and rx_overrun set. Stop=0: byte discarded, frame_err set. Return to IDLE after stop sample.
- Completion of a byte and a RXD read in the same cycle: new byte latched, rx_valid stays 1, no overrun.
- `irqout` = (IEN[0] & rx_valid) | (IEN[1] & tx_idle), registered.

## Timing
- Reset values: `UART_TX`=1, `irqout`=0, FIFO empty, rx_valid/flags/IEN/rx_byte=0, both FSMs IDLE.
- Reset asserted mid-frame: `UART_TX` goes 1 immediately, FIFO contents lost.
- Write to TXD at edge N with FSM IDLE: `UART_TX`=0 from edge N+1; frame occupies 10·BAUD_DIV clocks; back-to-back frames have no idle gap.
- RX latency: rx_valid rises at the edge after the stop-bit mid-sample, ≈ 9.5·BAUD_DIV+3 clocks after the start edge on the pin.
- `irqout` follows its condition by one clock.

## Configuration
- `UART_LOOPBACK_EN` defined: RX synchronizer input taken from internal TX output; `UART_RX` ignored; `UART_TX` pin held at 1.
- Undefined: normal pin operation as above.

## Test plan
- BAUD_DIV=16, write 0x55 to TXD -> `UART_TX` 0 one clock later, then 1,0,1,0,1,0,1,0, stop 1, each 16 clocks; CON[1] returns 1 after 160 clocks.
- Write 6 bytes back-to-back with TX_DEPTH=4, FSM idle -> first byte popped immediately, bytes 1–4 queued, 6th dropped, CON[5]=1; five frames contiguous on `UART_TX`.
- Drive frame 0xA3 on `UART_RX` -> CON[0]=1, RXD reads 0x000000A3, CON[0]=0 after read; with IEN=1 `irqout` rises then falls.
- Two frames without reading RXD -> RXD holds second byte, CON[3]=1; write 0x8 to CON -> CON[3]=0.
- Frame with stop bit 0, and a 4-clock low glitch -> first sets CON[4] with rx_valid 0; glitch produces no byte, no flag.
- `UART_LOOPBACK_EN` defined, write 0x3C to TXD -> RXD reads 0x3C after ~160 clocks, `UART_TX` pin stays 1; reset pulse mid-frame returns all outputs to reset values.
